// File: rtl/ecg_moving_avg_filter.sv
// Power-of-two boxcar average over the last 2^LOG2N ADC samples, one strobe per sample.
// Define ECG_MAF_DCREMOVE_EN to emit the average re-centred on mid-scale (two's complement).
module ecg_moving_avg_filter #(
  parameter int LOG2N = 3,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          dv_in,
  output logic [DW-1:0] data_out,
  output logic          dv_out,
  output logic          primed,
  output logic          overrun
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = DW + LOG2N;
  localparam logic [LOG2N:0] N_CNT = {1'b1, {LOG2N{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            dv_d;
  logic            sample_evt;
  logic [DW-1:0]   sample;
  logic [DW-1:0]   old;
  logic [SW-1:0]   sum;
  logic [LOG2N-1:0] wr_ptr;
  logic [LOG2N:0]  count;
  logic [DW-1:0]   mem [N];

  // Truncating divide by N: keep the top DW bits of the running sum.
  function automatic logic [DW-1:0] avg_of(input logic [SW-1:0] s);
    return s[SW-1:LOG2N];
  endfunction

  function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] avg);
`ifdef ECG_MAF_DCREMOVE_EN
    // Subtracting mid-scale from an unsigned word is an MSB flip.
    return avg ^ {1'b1, {(DW-1){1'b0}}};
`else
    return avg;
`endif
  endfunction

  assign sample_evt = dv_in & ~dv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_evt) state_nxt = READ;
      READ:    state_nxt = UPDATE;
      UPDATE:  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_d     <= 1'b0;
      sample   <= '0;
      old      <= '0;
      sum      <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      dv_out   <= 1'b0;
      primed   <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      dv_d   <= dv_in;
      dv_out <= 1'b0;
      if (sample_evt && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample_evt) sample <= data_in;
        end
        READ: begin
          old <= mem[wr_ptr];
        end
        // Window invariant: sum == sum of mem[], so add-then-subtract stays in range.
        UPDATE: begin
          sum         <= sum + SW'(sample) - SW'(old);
          mem[wr_ptr] <= sample;
          wr_ptr      <= wr_ptr + 1'b1;
          if (count != N_CNT) count <= count + 1'b1;
        end
        OUT: begin
          data_out <= out_fmt(avg_of(sum));
          dv_out   <= 1'b1;
          primed   <= (count == N_CNT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_moving_avg_filter.sv
// Bench for ecg_moving_avg_filter: vector table, random stream vs window model, corner sequences.
module tb_ecg_moving_avg_filter;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] data_in = '0;
  logic        dv_in = 1'b0;
  logic [11:0] data_out;
  logic        dv_out, primed, overrun;

  int total = 0;
  int bad   = 0;

  ecg_moving_avg_filter #(.LOG2N(LOG2N), .DW(12)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dv_in(dv_in),
    .data_out(data_out), .dv_out(dv_out), .primed(primed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference: the last N accepted samples as a plain queue.
  int win[$];
  int n_seen;
  logic exp_ov;

  function automatic void model_reset();
    win = {};
    for (int i = 0; i < N; i++) win.push_back(0);
    n_seen = 0;
    exp_ov = 1'b0;
  endfunction

  function automatic void model_push(int v);
    win.push_back(v);
    void'(win.pop_front());
    n_seen++;
  endfunction

  function automatic int model_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / N;
  endfunction

  function automatic logic model_primed();
    return n_seen >= N;
  endfunction

  function automatic logic [11:0] fmt(input int avg);
`ifdef ECG_MAF_DCREMOVE_EN
    return 12'(avg - 2048);
`else
    return 12'(avg);
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge: raise dv_in for hi cycles, then low for gap cycles, watching strobes.
  task automatic apply(input logic [11:0] v, input int hi, input int gap,
                       output int nstb, output int lat, output logic [11:0] dout, output logic prm);
    nstb = 0; lat = -1; dout = '0; prm = 1'b0;
    data_in = v;
    dv_in = 1'b1;
    for (int k = 1; k <= hi + gap; k++) begin
      @(negedge clk);
      if (dv_out) begin
        nstb++;
        if (lat < 0) begin lat = k; dout = data_out; prm = primed; end
      end
      if (k == hi) dv_in = 1'b0;
    end
  endtask

  task automatic run_one(input string nm, input logic [11:0] v, input int hi, input int gap,
                         input logic [11:0] exp_o, input logic exp_p);
    int nstb, lat;
    logic [11:0] d;
    logic p;
    apply(v, hi, gap, nstb, lat, d, p);
    check({nm, " strobes"}, nstb, 1);
    check({nm, " latency"}, lat, 4);
    check({nm, " data_out"}, int'(d), int'(exp_o));
    check({nm, " primed"}, int'(p), int'(exp_p));
    check({nm, " overrun"}, int'(overrun), int'(exp_ov));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dv_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst_before;
    logic [11:0] din;
    int          hi;
    logic [11:0] exp_avg;
    logic        exp_primed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [11:0] d, int hi, logic [11:0] e, logic p);
    vec_t t;
    t.rst_before = r; t.din = d; t.hi = hi; t.exp_avg = e; t.exp_primed = p;
    tbl.push_back(t);
  endfunction

  initial begin
    int nstb;
    logic [11:0] d;

    // Warm-up ramp with 800, then a step to 1600, then full-scale with a fresh window.
    for (int i = 1; i <= 8; i++) add(i == 1, 12'd800, 10, 12'(100 * i), i == 8);
    add(1'b0, 12'd800, 10, 12'd800, 1'b1);
    add(1'b0, 12'd800, 3, 12'd800, 1'b1);
    for (int i = 1; i <= 8; i++) add(1'b0, 12'd1600, 10, 12'(800 + 100 * i), 1'b1);
    add(1'b0, 12'd1600, 10, 12'd1600, 1'b1);
    add(1'b1, 12'd4095, 10, 12'd511, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd1023, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd1535, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd2047, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd2559, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd3071, 1'b0);
    add(1'b0, 12'd4095, 10, 12'd3583, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 12'd4095, 10, 12'd4095, 1'b1);

    model_reset();
    repeat (3) @(negedge clk);
    check("reset data_out", int'(data_out), 0);
    check("reset dv_out", int'(dv_out), 0);
    check("reset primed", int'(primed), 0);
    check("reset overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      model_push(tbl[i].din);
      run_one($sformatf("vec%0d", i), tbl[i].din, tbl[i].hi, 190,
              fmt(tbl[i].exp_avg), tbl[i].exp_primed);
    end

    // Random stream against the window model.
    for (int i = 0; i < 40; i++) begin
      logic [11:0] v;
      v = 12'($urandom_range(0, 4095));
      model_push(v);
      run_one($sformatf("rnd%0d", i), v, $urandom_range(1, 12), $urandom_range(5, 10),
              fmt(model_avg()), model_primed());
    end

    // dv_in held high for a long time: a single event.
    model_push(2000);
    run_one("held_high", 12'd2000, 1000, 10, fmt(model_avg()), model_primed());

    // Second rising edge while busy: dropped and flagged.
    do_reset();
    nstb = 0;
    d = '0;
    data_in = 12'd800;
    dv_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dv_out) begin nstb++; d = data_out; end
      if (k == 1) dv_in = 1'b0;
      if (k == 2) begin data_in = 12'd1600; dv_in = 1'b1; end
      if (k == 3) dv_in = 1'b0;
    end
    model_push(800);
    exp_ov = 1'b1;
    check("overrun strobes", nstb, 1);
    check("overrun data_out", int'(d), int'(fmt(100)));
    check("overrun flag", int'(overrun), 1);
    model_push(800);
    run_one("after_overrun", 12'd800, 5, 10, fmt(model_avg()), model_primed());

    // Reset asserted while the FSM is in UPDATE.
    data_in = 12'd800;
    dv_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset data_out", int'(data_out), 0);
    check("midreset dv_out", int'(dv_out), 0);
    check("midreset primed", int'(primed), 0);
    check("midreset overrun", int'(overrun), 0);
    dv_in = 1'b0;
    nstb = 0;
    repeat (2) begin @(negedge clk); if (dv_out) nstb++; end
    rst_n = 1'b1;
    model_reset();
    repeat (10) begin @(negedge clk); if (dv_out) nstb++; end
    check("midreset no strobe", nstb, 0);
    model_push(800);
    run_one("post_reset", 12'd800, 10, 10, fmt(100), 1'b0);

`ifdef ECG_MAF_DCREMOVE_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin model_push(2048); run_one("dc2048", 12'd2048, 5, 5, fmt(model_avg()), model_primed()); end
    check("dc mid-scale", int'(data_out), 12'h000);
    for (int i = 0; i < 8; i++) begin model_push(0); run_one("dc0", 12'd0, 5, 5, fmt(model_avg()), 1'b1); end
    check("dc zero", int'(data_out), 12'h800);
    for (int i = 0; i < 8; i++) begin model_push(4095); run_one("dc4095", 12'd4095, 5, 5, fmt(model_avg()), 1'b1); end
    check("dc full", int'(data_out), 12'h7FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
